// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types for the pipeline stall/flush sequencer.
// Holds the sequencer state enum, the default register-index width and the
// bundle that carries every hold/bubble control for one cycle.
package pipe_ctrl_pkg;

  // Default register-index width (RISC-V x0..x31).
  localparam int REG_W_DEFAULT = 5;

  // RUN: normal flow. PEND: a taken branch is waiting for the fetch to finish.
  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } ctrl_state_e;

  // One cycle's worth of PC and pipeline-register controls.
  typedef struct packed {
    logic pc_hold;
    logic pc_sel_redirect;
    logic ifid_hold;
    logic idex_hold;
    logic exmem_hold;
    logic memwb_hold;
    logic ifid_bubble;
    logic idex_bubble;
    logic exmem_bubble;
  } stage_ctrl_t;

  // Everything advances, nothing is cleared.
  localparam stage_ctrl_t CTRL_IDLE = '0;

  // Whole pipeline frozen while the data memory is busy.
  function automatic stage_ctrl_t freeze_all();
    stage_ctrl_t c;
    c            = CTRL_IDLE;
    c.pc_hold    = 1'b1;
    c.ifid_hold  = 1'b1;
    c.idex_hold  = 1'b1;
    c.exmem_hold = 1'b1;
    c.memwb_hold = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs and stage controls of the sequencer.
// master = pipeline side (drives hazard status, consumes controls),
// slave  = the sequencer itself.
interface pipeline_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
);
  logic             imem_busywait;
  logic             dmem_busywait;
  logic             ex_memRead;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_valid;
  logic             ex_redirect;

  logic             pc_hold;
  logic             pc_sel_redirect;
  logic             ifid_hold;
  logic             idex_hold;
  logic             exmem_hold;
  logic             memwb_hold;
  logic             ifid_bubble;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             redirect_pending;

  modport master (
    output imem_busywait, dmem_busywait, ex_memRead, ex_rd, id_rs1, id_rs2,
           id_valid, ex_redirect,
    input  pc_hold, pc_sel_redirect, ifid_hold, idex_hold, exmem_hold,
           memwb_hold, ifid_bubble, idex_bubble, exmem_bubble, redirect_pending
  );

  modport slave (
    input  imem_busywait, dmem_busywait, ex_memRead, ex_rd, id_rs1, id_rs2,
           id_valid, ex_redirect,
    output pc_hold, pc_sel_redirect, ifid_hold, idex_hold, exmem_hold,
           memwb_hold, ifid_bubble, idex_bubble, exmem_bubble, redirect_pending
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the valid
// instruction in ID. x0 is never a real dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_valid,
  output logic             hazard
);

  // Compare the load destination against both ID source operands.
  always_comb begin
    hazard = ex_memRead && (ex_rd != '0) && id_valid &&
             ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Turns memory busywait, load-use hazards and EX-stage redirects into PC and
// pipeline-register hold/bubble controls. A redirect that arrives during an
// outstanding fetch is parked in PEND until the fetch returns.
// Optional feature macro: PIPE_CTRL_PERF_EN adds stall/flush/defer counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic clock,
  input  logic reset,
  pipeline_hazard_ctrl_if.slave ctrl
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] redirect_defer_count
`endif
);

  ctrl_state_e state;
  ctrl_state_e state_next;
  stage_ctrl_t ctl;
  logic        load_use;

  load_use_detect #(.REG_W(REG_W)) u_load_use (
    .ex_memRead (ctrl.ex_memRead),
    .ex_rd      (ctrl.ex_rd),
    .id_rs1     (ctrl.id_rs1),
    .id_rs2     (ctrl.id_rs2),
    .id_valid   (ctrl.id_valid),
    .hazard     (load_use)
  );

  // Sequencer state register; reset always returns to RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Priority decode: reset, dmem freeze, redirect, pending redirect,
  // fetch miss, load-use, idle.
  always_comb begin
    ctl        = CTRL_IDLE;
    state_next = state;
    if (reset) begin
      ctl.ifid_bubble  = 1'b1;
      ctl.idex_bubble  = 1'b1;
      ctl.exmem_bubble = 1'b1;
      state_next       = RUN;
    end else if (ctrl.dmem_busywait) begin
      ctl = freeze_all();
    end else begin
      case (state)
        RUN: begin
          if (ctrl.ex_redirect) begin
            ctl.ifid_bubble = 1'b1;
            ctl.idex_bubble = 1'b1;
            if (ctrl.imem_busywait) begin
              ctl.pc_hold = 1'b1;
              state_next  = PEND;
            end else begin
              ctl.pc_sel_redirect = 1'b1;
            end
          end else if (ctrl.imem_busywait) begin
            ctl.pc_hold     = 1'b1;
            ctl.ifid_bubble = 1'b1;
          end else if (load_use) begin
            ctl.pc_hold     = 1'b1;
            ctl.ifid_hold   = 1'b1;
            ctl.idex_bubble = 1'b1;
          end
        end
        PEND: begin
          ctl.ifid_bubble = 1'b1;
          if (ctrl.imem_busywait) begin
            ctl.pc_hold = 1'b1;
          end else begin
            ctl.pc_sel_redirect = 1'b1;
            state_next          = RUN;
          end
        end
      endcase
    end
  end

  assign ctrl.pc_hold          = ctl.pc_hold;
  assign ctrl.pc_sel_redirect  = ctl.pc_sel_redirect;
  assign ctrl.ifid_hold        = ctl.ifid_hold;
  assign ctrl.idex_hold        = ctl.idex_hold;
  assign ctrl.exmem_hold       = ctl.exmem_hold;
  assign ctrl.memwb_hold       = ctl.memwb_hold;
  assign ctrl.ifid_bubble      = ctl.ifid_bubble;
  assign ctrl.idex_bubble      = ctl.idex_bubble;
  assign ctrl.exmem_bubble     = ctl.exmem_bubble;
  assign ctrl.redirect_pending = (state == PEND);

`ifdef PIPE_CTRL_PERF_EN
  // Performance counters: stalled cycles, redirects taken, deferred redirects.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles         <= '0;
      flush_count          <= '0;
      redirect_defer_count <= '0;
    end else begin
      stall_cycles         <= stall_cycles + CNT_W'(ctl.pc_hold);
      flush_count          <= flush_count + CNT_W'(ctl.pc_sel_redirect);
      redirect_defer_count <= redirect_defer_count +
                              CNT_W'((state == RUN) && (state_next == PEND));
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl.
// Stimulus pushes the expected controls of each cycle into a queue; a monitor
// on the falling edge pops and compares. Builds with or without
// PIPE_CTRL_PERF_EN.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if #(.REG_W(5)) bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count, redirect_defer_count;
`endif

  pipeline_hazard_ctrl #(
    .REG_W(5)
`ifdef PIPE_CTRL_PERF_EN
    , .CNT_W(32)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .ctrl  (bus)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles         (stall_cycles)
    , .flush_count          (flush_count)
    , .redirect_defer_count (redirect_defer_count)
`endif
  );

  // Order: pc_hold pc_sel ifid_h idex_h exmem_h memwb_h ifid_b idex_b exmem_b pend
  typedef struct {
    string       tag;
    int          cyc;
    logic [9:0]  outs;
    int unsigned stall;
    int unsigned flush;
    int unsigned defer;
  } exp_t;

  exp_t        scoreQ[$];
  exp_t        monE;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  bit          mDeferred = 1'b0;
  int unsigned mStall = 0, mFlush = 0, mDefer = 0;

  task automatic applyStimulus(input string tag, input bit rst, input bit dmem,
                               input bit imem, input bit red, input bit memRead,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input bit idv,
                               input bit chk);
    bit   hz, ph, ps, ih, xh, mh, wh, ib, xb, eb;
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    reset             = rst;
    bus.dmem_busywait = dmem;
    bus.imem_busywait = imem;
    bus.ex_redirect   = red;
    bus.ex_memRead    = memRead;
    bus.ex_rd         = rd;
    bus.id_rs1        = rs1;
    bus.id_rs2        = rs2;
    bus.id_valid      = idv;

    hz = memRead && (rd != 5'd0) && idv && (rd == rs1 || rd == rs2);
    {ph, ps, ih, xh, mh, wh, ib, xb, eb} = '0;
    if (rst) begin
      {ib, xb, eb} = 3'b111;
    end else if (dmem) begin
      {ph, ih, xh, mh, wh} = 5'b11111;
    end else if (mDeferred) begin
      ib = 1'b1;
      if (imem) ph = 1'b1; else ps = 1'b1;
    end else if (red) begin
      ib = 1'b1; xb = 1'b1;
      if (imem) ph = 1'b1; else ps = 1'b1;
    end else if (imem) begin
      ph = 1'b1; ib = 1'b1;
    end else if (hz) begin
      ph = 1'b1; ih = 1'b1; xb = 1'b1;
    end

    e.tag   = tag;
    e.cyc   = cyc;
    e.outs  = {ph, ps, ih, xh, mh, wh, ib, xb, eb, mDeferred};
    e.stall = mStall;
    e.flush = mFlush;
    e.defer = mDefer;
    if (chk) scoreQ.push_back(e);

    if (rst) begin
      mDeferred = 1'b0;
      mStall = 0; mFlush = 0; mDefer = 0;
    end else begin
      mStall += ph ? 1 : 0;
      mFlush += ps ? 1 : 0;
      if (!dmem && !mDeferred && red && imem) begin
        mDeferred = 1'b1;
        mDefer++;
      end else if (!dmem && mDeferred && !imem) begin
        mDeferred = 1'b0;
      end
    end
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [9:0] got;
    got = {bus.pc_hold, bus.pc_sel_redirect, bus.ifid_hold, bus.idex_hold,
           bus.exmem_hold, bus.memwb_hold, bus.ifid_bubble, bus.idex_bubble,
           bus.exmem_bubble, bus.redirect_pending};
    total++;
    if (got !== e.outs) begin
      bad++;
      $display("[TB] FAIL %s cyc %0d ctrl: got %b want %b", e.tag, e.cyc, got, e.outs);
    end
`ifdef PIPE_CTRL_PERF_EN
    total++;
    if (stall_cycles !== e.stall) begin
      bad++;
      $display("[TB] FAIL %s cyc %0d stall_cycles: got %0d want %0d", e.tag, e.cyc, stall_cycles, e.stall);
    end
    total++;
    if (flush_count !== e.flush) begin
      bad++;
      $display("[TB] FAIL %s cyc %0d flush_count: got %0d want %0d", e.tag, e.cyc, flush_count, e.flush);
    end
    total++;
    if (redirect_defer_count !== e.defer) begin
      bad++;
      $display("[TB] FAIL %s cyc %0d redirect_defer_count: got %0d want %0d", e.tag, e.cyc, redirect_defer_count, e.defer);
    end
`endif
  endtask

  // Monitor: compare DUT controls against the oldest expectation each cycle.
  always @(negedge clock) begin
    if (scoreQ.size() > 0) begin
      monE = scoreQ.pop_front();
      checkOutput(monE);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    reset             = 1'b1;
    bus.dmem_busywait = 1'b0;
    bus.imem_busywait = 1'b0;
    bus.ex_redirect   = 1'b0;
    bus.ex_memRead    = 1'b0;
    bus.ex_rd         = '0;
    bus.id_rs1        = '0;
    bus.id_rs2        = '0;
    bus.id_valid      = 1'b0;

    applyStimulus("init",  1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    applyStimulus("reset", 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    idle("idle");

    applyStimulus("ld_use",  0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 1, 1);
    applyStimulus("ld_done", 0, 0, 0, 0, 0, 5'd5, 5'd1, 5'd5, 1, 1);
    applyStimulus("ld_x0",   0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);

    applyStimulus("br_taken", 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    idle("br_after");

    applyStimulus("br_miss", 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    for (int i = 0; i < 3; i++)
      applyStimulus("pend_wait", 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    applyStimulus("pend_exit", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    idle("pend_after");

    for (int i = 0; i < 3; i++)
      applyStimulus("dmem_frz", 0, 1, 0, 1, 1, 5'd7, 5'd7, 5'd2, 1, 1);
    applyStimulus("dmem_rel", 0, 0, 0, 1, 1, 5'd7, 5'd7, 5'd2, 1, 1);
    idle("dmem_after");

    applyStimulus("br_miss2",  0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    applyStimulus("pend_dmem", 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    applyStimulus("rst_pend",  1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    idle("after_rst");

    for (int i = 0; i < 500; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 99) < 15),
                    ($urandom_range(0, 99) < 40),
                    ($urandom_range(0, 99) < 25),
                    ($urandom_range(0, 99) < 50),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 99) < 80),
                    1);
    end

    @(posedge clock);
    #2;
    total++;
    if (scoreQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending expectations want 0", scoreQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
